m_unit_seq: RTL and testbench
=============================

Name: m_unit_seq

Overview:
Parametrised, multi-cycle RV32/RV64-style M-extension co-processor that attaches to the core's PCPI port. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands. Compared with the existing fixed 32-bit controller it adds:
- configurable radix (bits retired per divide cycle);
- configurable multiplier latency;
- early-out for special cases;
- mid-operation abort;
- a one-entry quotient/remainder cache, so a DIV followed by a REM on the same operands (or the reverse) completes in one cycle.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- DIV_BITS, 2, quotient bits retired per DIV-state cycle; legal values 1, 2 or 4; XLEN % DIV_BITS == 0.
- MUL_LAT, 2, cycles spent in MUL state (>=1); extra cycles are register stages for retiming.
- CACHE_EN, 1, enables the one-entry div/rem result cache.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcpi_valid  in  1  core presents an instruction; held high until pcpi_ready or abort.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  XLEN  operand 1.
- pcpi_rs2  in  XLEN  operand 2.
- pcpi_wr  out  1  write-back enable; pulses together with pcpi_ready.
- pcpi_rd  out  XLEN  result; valid only while pcpi_ready=1, 0 otherwise.
- pcpi_wait  out  1  unit has claimed the instruction and is busy.
- pcpi_ready  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - state=IDLE; counter=0; cache_valid=0.
  - pcpi_wr, pcpi_ready, pcpi_wait and pcpi_rd all 0.
  - An asserted reset mid-operation discards all work; no ready pulse is produced.
- Decode hit = pcpi_valid && opcode==OP && funct7==MULDIV. Non-hits are ignored with no outputs, so the core's timeout logic applies.
- States: IDLE, DIV, MUL, DONE.
- IDLE:
  - On a decode hit: pcpi_wait=1 combinationally in this cycle.
  - Latch func3, |rs1| and |rs2| (negated only if the operand is signed for this func3 and its MSB is 1), neg_q = sign(rs1)^sign(rs2), and neg_r = sign(rs1).
  - Next state:
    - mul ops go to MUL;
    - div/rem ops go to DONE if a special case or cache hit applies, else to DIV.
- Special cases (result latched at acceptance, sign fix bypassed):
  - rs2==0: quotient = all ones; remainder = rs1.
  - Signed, rs1 = 1<<(XLEN-1) and rs2 = all ones: quotient = rs1; remainder = 0.
  - |rs1| < |rs2|: quotient = 0; remainder = rs1.
- Cache:
  - Hit when CACHE_EN, cache_valid, rs1/rs2 equal to the stored operands, and signedness class (DIV/REM vs DIVU/REMU) matches.
  - A hit returns the stored quotient or remainder.
  - The cache is written only when the DIV state completes normally. It stores rs1, rs2, class, and the signed-fixed quotient and remainder.
  - Special cases and mul ops neither write nor read it.
- DIV:
  - Restoring division, DIV_BITS quotient bits per cycle, MSB first.
  - Runs for exactly XLEN/DIV_BITS cycles (counter 0..XLEN/DIV_BITS-1), then goes to DONE.
- MUL:
  - (XLEN+1)x(XLEN+1) signed product of the sign/zero-extended operands, per func3: MULH s*s; MULHSU s*u; MULHU and MUL u*u.
  - Stays MUL_LAT cycles, then goes to DONE.
  - MUL returns bits [XLEN-1:0]; the others return [2*XLEN-1:XLEN].
- DONE:
  - pcpi_ready=1, pcpi_wr=1, pcpi_wait=0, pcpi_rd = final result.
  - Quotient is negated if neg_q; remainder is negated if neg_r (signed ops only).
  - Next state is IDLE unconditionally. A new instruction is accepted at the earliest on the cycle after DONE.
- pcpi_wait = 1 in DIV and MUL.
- Latency (acceptance cycle = 0), cycle in which pcpi_ready is high:
  - div: XLEN/DIV_BITS + 1;
  - mul: MUL_LAT + 1;
  - special case or cache hit: 1.
- Abort: pcpi_valid low in DIV or MUL sends the unit to IDLE next cycle. There is no ready pulse and no cache write; the cache contents are kept.
- pcpi_valid low in DONE: the ready pulse is still issued, and the core ignores it.

Decomposition:
- Package m_pkg holds:
  - opcode/funct7 constants;
  - func3 enum (MUL..REMU);
  - state_t typedef;
  - decode helpers: is_mul, is_div, is_rem, rs1_signed, rs2_signed.
- Sub-module m_div_iter: a combinational DIV_BITS-step restoring-division slice.
  - Inputs: partial remainder, divisor, dividend bits.
  - Outputs: next remainder, quotient bits.
  - It is instantiated once in the DIV datapath.

Test Plan (XLEN=32, DIV_BITS=2, MUL_LAT=2, CACHE_EN=1):
- DIV rs1=-7, rs2=2: ready at cycle 17, rd=0xFFFFFFFD. Then REM with the same operands: ready at cycle 1, rd=0xFFFFFFFF (cache hit).
- MULH 0x80000000*0x80000000: rd=0x40000000 at cycle 3. MULHSU 0xFFFFFFFF*0xFFFFFFFF: rd=0xFFFFFFFF. MUL 7*-3: rd=0xFFFFFFEB.
- DIVU x/0 gives rd=0xFFFFFFFF at cycle 1; REM 5/0 gives rd=5. DIV 0x80000000/0xFFFFFFFF gives rd=0x80000000; REM on the same operands gives rd=0.
- DIVU 3/10: rd=0 at cycle 1. REMU 3/10: rd=3.
- DIVU 100/7 with pcpi_valid dropped at cycle 5: no ready; the unit is IDLE at cycle 6. A repeat of DIVU 100/7 gives rd=14 at cycle 17 (not a cache hit).
- Reset asserted during DIV cycle 8: all outputs 0 immediately; the next DIV 100/7 takes 17 cycles (cache was cleared).

Source files
------------

// File: rtl/m_unit_seq_pkg.sv
// ============================================================================
// Module  : m_pkg
// Brief   : Shared decode constants, types and helpers for the M-extension unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package m_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } func3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_mul(input func3_e f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_MULHU);
  endfunction

  function automatic logic is_div(input func3_e f);
    return (f == F3_DIV) || (f == F3_DIVU);
  endfunction

  function automatic logic is_rem(input func3_e f);
    return (f == F3_REM) || (f == F3_REMU);
  endfunction

  function automatic logic rs1_signed(input func3_e f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic rs2_signed(input func3_e f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_unit_seq_div_iter.sv
// ============================================================================
// Module  : m_div_iter
// Brief   : Combinational DIV_BITS-step restoring-division slice, MSB first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module m_div_iter #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 2
) (
  input  logic [XLEN-1:0]     i_rem,
  input  logic [XLEN-1:0]     i_divisor,
  input  logic [DIV_BITS-1:0] i_dvd_bits,
  output logic [XLEN-1:0]     o_rem,
  output logic [DIV_BITS-1:0] o_q_bits
);

  logic [XLEN-1:0] w_rem [0:DIV_BITS];

  assign w_rem[0] = i_rem;

  // Partial remainder stays below the divisor, so the trial fits in XLEN+1 bits.
  for (genvar i = 0; i < DIV_BITS; i++) begin : g_step
    logic [XLEN:0] w_trial;
    logic          w_ge;
    assign w_trial                = {w_rem[i], i_dvd_bits[DIV_BITS-1-i]};
    assign w_ge                   = (w_trial >= {1'b0, i_divisor});
    assign o_q_bits[DIV_BITS-1-i] = w_ge;
    assign w_rem[i+1]             = w_ge ? XLEN'(w_trial - {1'b0, i_divisor})
                                         : w_trial[XLEN-1:0];
  end

  assign o_rem = w_rem[DIV_BITS];

endmodule

`default_nettype wire

// File: rtl/m_unit_seq.sv
// ============================================================================
// Module  : m_unit_seq
// Brief   : Multi-cycle PCPI M-extension unit with radix divider and div/rem cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

module m_unit_seq
  import m_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 2,
  parameter int MUL_LAT  = 2,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int DIV_STEPS = XLEN / DIV_BITS;
  localparam int CNT_MAX   = (DIV_STEPS > MUL_LAT) ? DIV_STEPS : MUL_LAT;
  localparam int CNT_W     = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(DIV_STEPS - 1);
  localparam logic [CNT_W-1:0] C_MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [XLEN-1:0]  C_MIN      = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  func3_e            func3_q, func3_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [XLEN-1:0]   prem_q, prem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              c_valid_q, c_valid_d;
  logic              c_sgn_q, c_sgn_d;
  logic [XLEN-1:0]   c_rs1_q, c_rs1_d;
  logic [XLEN-1:0]   c_rs2_q, c_rs2_d;
  logic [XLEN-1:0]   c_quo_q, c_quo_d;
  logic [XLEN-1:0]   c_rem_q, c_rem_d;

  // Decode and acceptance-time classification
  logic            w_hit;
  func3_e          w_f3;
  logic            w_s1, w_s2, w_sgn;
  logic [XLEN-1:0] w_abs1, w_abs2;
  logic            w_spec_zero, w_spec_ovf, w_spec_small, w_cache_hit;
  logic            w_unused_insn;

  assign w_hit  = pcpi_valid && (pcpi_insn[6:0] == OPCODE_OP) &&
                  (pcpi_insn[31:25] == FUNCT7_MULDIV);
  assign w_f3   = func3_e'(pcpi_insn[14:12]);
  assign w_s1   = rs1_signed(w_f3) && pcpi_rs1[XLEN-1];
  assign w_s2   = rs2_signed(w_f3) && pcpi_rs2[XLEN-1];
  assign w_sgn  = rs1_signed(w_f3);
  assign w_abs1 = w_s1 ? (-pcpi_rs1) : pcpi_rs1;
  assign w_abs2 = w_s2 ? (-pcpi_rs2) : pcpi_rs2;

  assign w_spec_zero  = (pcpi_rs2 == '0);
  assign w_spec_ovf   = w_sgn && (pcpi_rs1 == C_MIN) && (pcpi_rs2 == '1);
  assign w_spec_small = (w_abs1 < w_abs2);
  assign w_cache_hit  = CACHE_EN && c_valid_q && (pcpi_rs1 == c_rs1_q) &&
                        (pcpi_rs2 == c_rs2_q) && (w_sgn == c_sgn_q);

  assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Divider datapath
  logic [XLEN-1:0]     w_rem_next, w_quo_next, w_fix_quo, w_fix_rem;
  logic [DIV_BITS-1:0] w_q_bits;

  m_div_iter #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div_iter (
    .i_rem      (prem_q),
    .i_divisor  (dvs_q),
    .i_dvd_bits (quo_q[XLEN-1 -: DIV_BITS]),
    .o_rem      (w_rem_next),
    .o_q_bits   (w_q_bits)
  );

  assign w_quo_next = {quo_q[XLEN-DIV_BITS-1:0], w_q_bits};
  assign w_fix_quo  = neg_quo_q ? (-w_quo_next) : w_quo_next;
  assign w_fix_rem  = neg_rem_q ? (-w_rem_next) : w_rem_next;

  // Truncated 2*XLEN product is identical for the XLEN+1-bit signed view.
  logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
  assign w_mul_a = {{XLEN{rs1_signed(func3_q) & op1_q[XLEN-1]}}, op1_q};
  assign w_mul_b = {{XLEN{rs2_signed(func3_q) & op2_q[XLEN-1]}}, op2_q};
  assign w_prod  = w_mul_a * w_mul_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func3_d   = func3_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    prem_d    = prem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rd_d      = rd_q;
    c_valid_d = c_valid_q;
    c_sgn_d   = c_sgn_q;
    c_rs1_d   = c_rs1_q;
    c_rs2_d   = c_rs2_q;
    c_quo_d   = c_quo_q;
    c_rem_d   = c_rem_q;

    case (state_q)
      S_IDLE: begin
        if (w_hit) begin
          func3_d   = w_f3;
          neg_quo_d = w_s1 ^ w_s2;
          neg_rem_d = w_s1;
          op1_d     = pcpi_rs1;
          op2_d     = pcpi_rs2;
          cnt_d     = '0;
          prem_d    = '0;
          quo_d     = w_abs1;
          dvs_d     = w_abs2;
          if (is_mul(w_f3)) begin
            state_d = S_MUL;
          end else if (w_spec_zero) begin
            rd_d    = is_rem(w_f3) ? pcpi_rs1 : '1;
            state_d = S_DONE;
          end else if (w_spec_ovf) begin
            rd_d    = is_rem(w_f3) ? '0 : pcpi_rs1;
            state_d = S_DONE;
          end else if (w_spec_small) begin
            rd_d    = is_rem(w_f3) ? pcpi_rs1 : '0;
            state_d = S_DONE;
          end else if (w_cache_hit) begin
            rd_d    = is_rem(w_f3) ? c_rem_q : c_quo_q;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end

      S_DIV: begin
        if (!pcpi_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          prem_d = w_rem_next;
          quo_d  = w_quo_next;
          if (cnt_q == C_DIV_LAST) begin
            rd_d    = is_rem(func3_q) ? w_fix_rem : w_fix_quo;
            state_d = S_DONE;
            if (CACHE_EN) begin
              c_valid_d = 1'b1;
              c_sgn_d   = rs1_signed(func3_q);
              c_rs1_d   = op1_q;
              c_rs2_d   = op2_q;
              c_quo_d   = w_fix_quo;
              c_rem_d   = w_fix_rem;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_MUL: begin
        if (!pcpi_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_MUL_LAST) begin
          rd_d    = (func3_q == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      func3_q   <= F3_MUL;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      prem_q    <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rd_q      <= '0;
      c_valid_q <= 1'b0;
      c_sgn_q   <= 1'b0;
      c_rs1_q   <= '0;
      c_rs2_q   <= '0;
      c_quo_q   <= '0;
      c_rem_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func3_q   <= func3_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      prem_q    <= prem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rd_q      <= rd_d;
      c_valid_q <= c_valid_d;
      c_sgn_q   <= c_sgn_d;
      c_rs1_q   <= c_rs1_d;
      c_rs2_q   <= c_rs2_d;
      c_quo_q   <= c_quo_d;
      c_rem_q   <= c_rem_d;
    end
  end

  // Reset gates the combinational claim so outputs drop as soon as reset rises.
  assign pcpi_wait  = !reset && ((state_q == S_IDLE && w_hit) ||
                                 (state_q == S_DIV) || (state_q == S_MUL));
  assign pcpi_ready = (state_q == S_DONE);
  assign pcpi_wr    = (state_q == S_DONE);
  assign pcpi_rd    = (state_q == S_DONE) ? rd_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_m_unit_seq.sv
// Randomized bench for m_unit_seq (XLEN=32, DIV_BITS=2, MUL_LAT=2, CACHE_EN=1)
// against an arithmetic reference model with a one-entry cache model.
`default_nettype none

module tb_m_unit_seq;

  logic        clk;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  int n_checks;
  int n_pass;

  // reference cache: last normally completed division
  bit          mc_valid;
  logic [31:0] mc_a, mc_b;
  bit          mc_sgn;

  m_unit_seq #(
    .XLEN     (32),
    .DIV_BITS (2),
    .MUL_LAT  (2),
    .CACHE_EN (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f, 5'd3, 7'b0110011};
  endfunction

  function automatic bit signed_div(input logic [2:0] f);
    return (f == 3'd4) || (f == 3'd6);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    longint sa, sb, ma, mb;
    bit     sg;
    sg = signed_div(f);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = sg ? ((sa < 0) ? -sa : sa) : longint'({32'b0, a});
    mb = sg ? ((sb < 0) ? -sb : sb) : longint'({32'b0, b});
    if (b == 0) return 1'b1;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return ma < mb;
  endfunction

  function automatic bit model_hit(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    return mc_valid && mc_a == a && mc_b == b && mc_sgn == signed_div(f);
  endfunction

  // abort_cyc < 0: no abort; otherwise pcpi_valid drops during that cycle
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int abort_cyc);
    int          lat_exp, lat;
    logic [31:0] rd_exp, rd_got;
    bit          is_m, normal;
    is_m    = (f < 3'd4);
    normal  = !is_m && !is_special(f, a, b) && !model_hit(f, a, b);
    lat_exp = is_m ? 3 : (normal ? 17 : 1);
    rd_exp  = ref_result(f, a, b);
    lat     = -1;
    rd_got  = '0;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(f, 7'b0000001);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    #1;
    check("accept_wait_rd", {31'd0, pcpi_wait, pcpi_rd}, {31'd0, 1'b1, 32'd0});
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (pcpi_ready) begin
        lat    = c;
        rd_got = pcpi_rd;
        check("done_wr_wait", {62'd0, pcpi_wr, pcpi_wait}, 64'd2);
        break;
      end
      if (c == abort_cyc) begin
        @(negedge clk);
        pcpi_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle", {pcpi_ready, pcpi_wait, pcpi_rd}, 34'd0);
        return;
      end
    end
    @(negedge clk);
    pcpi_valid = 1'b0;
    check("latency", 64'(lat), 64'(lat_exp));
    check("rd", {32'd0, rd_got}, {32'd0, rd_exp});
    if (normal) begin
      mc_valid = 1'b1;
      mc_a     = a;
      mc_b     = b;
      mc_sgn   = signed_div(f);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    int          ab;
    n_checks   = 0;
    n_pass     = 0;
    mc_valid   = 1'b0;
    mc_a       = '0;
    mc_b       = '0;
    mc_sgn     = 1'b0;
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {pcpi_wr, pcpi_ready, pcpi_wait, pcpi_rd}, 35'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed cases
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
    run_op(3'd5, 32'd123, 32'd0, -1);
    run_op(3'd6, 32'd5, 32'd0, -1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(3'd5, 32'd3, 32'd10, -1);
    run_op(3'd7, 32'd3, 32'd10, -1);
    run_op(3'd5, 32'd100, 32'd7, 5);
    run_op(3'd5, 32'd100, 32'd7, -1);
    run_op(3'd7, 32'd100, 32'd7, -1);

    // non-M instruction on the OP opcode is ignored
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(3'd4, 7'b0000000);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("nonhit_quiet", {pcpi_wait, pcpi_ready}, 2'd0);
      @(negedge clk);
    end
    pcpi_valid = 1'b0;

    // reset in the middle of a signed divide
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(3'd4, 7'b0000001);
    pcpi_rs1   = 32'd100;
    pcpi_rs2   = 32'd7;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid_div", {pcpi_wr, pcpi_ready, pcpi_wait, pcpi_rd}, 35'd0);
    @(negedge clk);
    pcpi_valid = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    mc_valid = 1'b0;
    run_op(3'd5, 32'd100, 32'd7, -1);
    run_op(3'd4, 32'd100, 32'd7, -1);

    // randomized mix with operand reuse and occasional aborts
    ra = 32'd1;
    rb = 32'd1;
    for (int i = 0; i < 80; i++) begin
      rf = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        ra = rnd_operand();
        rb = rnd_operand();
      end
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : -1;
      run_op(rf, ra, rb, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
